voice_scheduler: RTL and testbench
==================================

// Module: voice_scheduler
// PURPOSE
//  Frame sequencer for the time-multiplexed voice engine. On each sample_tick_i it snapshots the
//  per-voice configuration and runs every enabled voice through the engine once, in index order.
//  It collects the voice samples and presents them as one registered frame to the filter/mixer stage.
// PARAMETERS
//  NUM_VOICES      3   voices per frame (1..4); voice index width is 2
//  TIMEOUT_CYCLES  15  WAIT-state cycles without mv_ready_i before the voice is abandoned
// PORTS
//  clk_i           in   1        system clock (50 MHz)
//  rst_ni          in   1        reset, synchronous, active-low
//  sample_tick_i   in   1        one-cycle frame request (50 kHz)
//  voice_en_i      in   NV       per-voice enable mask (NV = NUM_VOICES)
//  freq_i          in   NV*16    frequency words; voice v at [16v+:16]
//  pw_i            in   NV*12    pulse widths; voice v at [12v+:12]
//  wave_sel_i      in   NV*4     one-hot waveform selects
//  sync_i          in   NV       hard-sync enables
//  ring_i          in   NV       ring-mod enables
//  clear_err_i     in   1        clears sticky error flags
//  mv_start_o      out  1        engine start strobe
//  mv_voice_o      out  2        engine active-voice index
//  mv_freq_o       out  16       mv_pw_o out 12, mv_wave_o out 4, mv_sync_o out 1, mv_ring_o out 1
//  mv_ready_i      in   1        engine done strobe; mv_wave_i is valid in this cycle
//  mv_wave_i       in   10 s     engine sample
//  voice_o         out  NV*10 s  registered frame samples; voice v at [10v+:10]
//  sample_valid_o  out  1        one-cycle pulse when voice_o is updated
//  busy_o          out  1        high whenever the state is not IDLE
//  err_overrun_o   out  1        sticky: tick arrived while busy
//  err_timeout_o   out  1        sticky: engine did not return ready in time
// BEHAVIOUR
//  Reset (rst_ni low at clk edge): state IDLE; all outputs 0; shadow config 0; holding regs 0.
//  FSM (Moore):
//   - IDLE: tick -> snapshot all config inputs into shadow regs; v = first enabled voice -> START.
//     If no voice is enabled -> DONE.
//   - START: mv_start_o=1 for exactly one cycle -> WAIT; clear timeout counter.
//   - WAIT: on mv_ready_i, hold[v] <= mv_wave_i.
//     If no higher enabled voice remains -> DONE; else v = next enabled voice -> START.
//     If the counter reaches TIMEOUT_CYCLES first: hold[v] <= 0, set err_timeout_o, advance as above.
//   - DONE: voice_o <= hold; sample_valid_o <= 1 (visible next cycle) -> IDLE.
//  mv_voice_o and the mv_* config fields are driven from the shadow regs for v.
//  They are held stable from START through the WAIT exit cycle; mv_voice_o keeps its last value in IDLE.
//  Disabled voices are never started; their hold entry is forced to 0 at snapshot.
//  Latency with a 3-cycle engine, all 3 voices enabled, tick at cycle 0:
//   START at cycles 1, 5, 9; ready at 4, 8, 12; DONE at 13; sample_valid_o and voice_o at cycle 14.
//   With all voices disabled, sample_valid_o is at cycle 2.
//  A tick while not IDLE is ignored (frame not restarted) and sets err_overrun_o.
//  A tick in the same cycle as the DONE->IDLE exit is also ignored and flagged.
//  mv_ready_i outside WAIT is ignored.
//  clear_err_i clears both flags. If an error event occurs in the same cycle, the set wins.
//  Config input changes mid-frame have no effect until the next tick (shadow isolation).
//  Reset mid-frame: return to IDLE next cycle; no sample_valid_o; voice_o cleared.
// CONFIGURATION
//  VOICE_SCHED_MIX_EN defined: adds output mix_o (12 bit signed).
//   mix_o = sign-extended sum of hold[0..NV-1], registered in DONE alongside voice_o; no saturation.
//  Not defined: the mix_o port does not exist and no adder is built.
// STRUCTURE
//  Package voice_sched_pkg: sched_state_e {IDLE, START, WAIT, DONE}; FREQ_W=16, PW_W=12, WSEL_W=4,
//   SAMPLE_W=10, VIDX_W=2.
//  Sub-module voice_cfg_shadow: snapshot register bank plus per-index read mux (shadow regs -> mv_*).
// TESTING
//  1. 3 voices enabled, engine model with ready 3 cycles after start, tick@0 ->
//     starts at 1/5/9, valid@14, voice_o = model samples.
//  2. voice_en_i=3'b101, tick -> voice 1 never started (mv_voice_o never 1); voice_o[1]=0; valid@10.
//  3. Change freq_i[0] from 16'h1234 to 16'h4321 at cycle 3 of a frame ->
//     mv_freq_o stays 16'h1234 for that frame; the next frame uses 16'h4321.
//  4. Model never asserts ready for voice 1 -> err_timeout_o=1 after 15 WAIT cycles;
//     voice_o[1]=0; voice 2 still processed; valid pulses.
//  5. Second tick at cycle 6 -> err_overrun_o=1; frame completes unchanged;
//     clear_err_i drops the flag next cycle.
//  6. VOICE_SCHED_MIX_EN defined, samples 511, 511, -512 -> mix_o = 510; rst_ni low at cycle 7
//     -> IDLE, no valid, outputs 0.

Source files
------------

// File: rtl/voice_sched_pkg.sv
// voice_sched_pkg: shared types, field widths and the enabled-voice search used by the voice scheduler
package voice_sched_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} sched_state_e;
  localparam int FREQ_W = 16;
  localparam int PW_W = 12;
  localparam int WSEL_W = 4;
  localparam int SAMPLE_W = 10;
  localparam int VIDX_W = 2;
  // Lowest enabled voice at or above 'from'; MSB of the result flags that one was found.
  function automatic logic [VIDX_W:0] find_voice(input logic [3:0] en, input logic [VIDX_W:0] from);
    find_voice = '0;
    for (int i = 3; i >= 0; i--)
      if (en[i] && (VIDX_W + 1)'(i) >= from) find_voice = {1'b1, VIDX_W'(i)};
  endfunction
endpackage

// File: rtl/voice_cfg_shadow.sv
// voice_cfg_shadow: per-frame snapshot of voice configuration with a per-index read mux
// Ports: clk_i/rst_ni (sync active-low), load_i snapshots en/freq/pw/wave_sel/sync/ring buses;
// sel_i picks the voice whose shadowed fields appear on freq_o/pw_o/wave_o/sync_o/ring_o; en_o is the shadowed mask.
module voice_cfg_shadow
  import voice_sched_pkg::*;
#(
  parameter int NUM_VOICES = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           load_i,
  input  logic [NUM_VOICES-1:0]          en_i,
  input  logic [NUM_VOICES*FREQ_W-1:0]   freq_i,
  input  logic [NUM_VOICES*PW_W-1:0]     pw_i,
  input  logic [NUM_VOICES*WSEL_W-1:0]   wave_sel_i,
  input  logic [NUM_VOICES-1:0]          sync_i,
  input  logic [NUM_VOICES-1:0]          ring_i,
  input  logic [VIDX_W-1:0]              sel_i,
  output logic [NUM_VOICES-1:0]          en_o,
  output logic [FREQ_W-1:0]              freq_o,
  output logic [PW_W-1:0]                pw_o,
  output logic [WSEL_W-1:0]              wave_o,
  output logic                           sync_o,
  output logic                           ring_o
);
  logic [NUM_VOICES-1:0] en_q, sync_q, ring_q;
  logic [NUM_VOICES*FREQ_W-1:0] freq_q;
  logic [NUM_VOICES*PW_W-1:0] pw_q;
  logic [NUM_VOICES*WSEL_W-1:0] wave_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_q <= '0;
      freq_q <= '0;
      pw_q <= '0;
      wave_q <= '0;
      sync_q <= '0;
      ring_q <= '0;
    end else if (load_i) begin
      en_q <= en_i;
      freq_q <= freq_i;
      pw_q <= pw_i;
      wave_q <= wave_sel_i;
      sync_q <= sync_i;
      ring_q <= ring_i;
    end
  end
  assign en_o = en_q;
  always_comb begin
    freq_o = '0;
    pw_o = '0;
    wave_o = '0;
    sync_o = 1'b0;
    ring_o = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (sel_i == VIDX_W'(i)) begin
        freq_o = freq_q[i*FREQ_W +: FREQ_W];
        pw_o = pw_q[i*PW_W +: PW_W];
        wave_o = wave_q[i*WSEL_W +: WSEL_W];
        sync_o = sync_q[i];
        ring_o = ring_q[i];
      end
  end
endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: per-tick frame sequencer that runs each enabled voice through the shared engine
// Ports: clk_i, rst_ni (sync active-low), sample_tick_i frame request, per-voice config buses
// (voice_en_i, freq_i, pw_i, wave_sel_i, sync_i, ring_i), clear_err_i; engine handshake mv_start_o/
// mv_voice_o/mv_* config out, mv_ready_i/mv_wave_i back; frame out voice_o + sample_valid_o; busy_o;
// sticky err_overrun_o/err_timeout_o. Define VOICE_SCHED_MIX_EN to add the signed 12-bit mix_o sum output.
module voice_scheduler
  import voice_sched_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              sample_tick_i,
  input  logic [NUM_VOICES-1:0]             voice_en_i,
  input  logic [NUM_VOICES*FREQ_W-1:0]      freq_i,
  input  logic [NUM_VOICES*PW_W-1:0]        pw_i,
  input  logic [NUM_VOICES*WSEL_W-1:0]      wave_sel_i,
  input  logic [NUM_VOICES-1:0]             sync_i,
  input  logic [NUM_VOICES-1:0]             ring_i,
  input  logic                              clear_err_i,
  output logic                              mv_start_o,
  output logic [VIDX_W-1:0]                 mv_voice_o,
  output logic [FREQ_W-1:0]                 mv_freq_o,
  output logic [PW_W-1:0]                   mv_pw_o,
  output logic [WSEL_W-1:0]                 mv_wave_o,
  output logic                              mv_sync_o,
  output logic                              mv_ring_o,
  input  logic                              mv_ready_i,
  input  logic signed [SAMPLE_W-1:0]        mv_wave_i,
  output logic [NUM_VOICES*SAMPLE_W-1:0]    voice_o,
  output logic                              sample_valid_o,
  output logic                              busy_o,
  output logic                              err_overrun_o,
  output logic                              err_timeout_o
`ifdef VOICE_SCHED_MIX_EN
  , output logic signed [11:0]              mix_o
`endif
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  sched_state_e state;
  logic [VIDX_W-1:0] cur_q;
  logic [CNT_W-1:0] cnt_q;
  logic signed [SAMPLE_W-1:0] hold_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] sh_en;
  logic [3:0] en_now, en_shd;
  logic [VIDX_W:0] first, nxt;
  logic expired, adv;
  voice_cfg_shadow #(.NUM_VOICES(NUM_VOICES)) u_shadow (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(state == IDLE && sample_tick_i),
    .en_i(voice_en_i), .freq_i(freq_i), .pw_i(pw_i), .wave_sel_i(wave_sel_i),
    .sync_i(sync_i), .ring_i(ring_i), .sel_i(cur_q), .en_o(sh_en),
    .freq_o(mv_freq_o), .pw_o(mv_pw_o), .wave_o(mv_wave_o), .sync_o(mv_sync_o), .ring_o(mv_ring_o)
  );
  always_comb begin
    en_now = '0;
    en_shd = '0;
    en_now[NUM_VOICES-1:0] = voice_en_i;
    en_shd[NUM_VOICES-1:0] = sh_en;
  end
  // The first voice comes from the live mask (snapshot happens the same cycle); later ones from the shadow.
  assign first = find_voice(en_now, '0);
  assign nxt = find_voice(en_shd, {1'b0, cur_q} + 1'b1);
  assign expired = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign adv = state == WAIT && (mv_ready_i || expired);
  assign mv_start_o = state == START;
  assign busy_o = state != IDLE;
  assign mv_voice_o = cur_q;
`ifdef VOICE_SCHED_MIX_EN
  logic signed [11:0] mix_sum;
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      mix_sum = mix_sum + {{(12 - SAMPLE_W){hold_q[i][SAMPLE_W-1]}}, hold_q[i]};
  end
`endif
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      cur_q <= '0;
      cnt_q <= '0;
      hold_q <= '{default: '0};
      voice_o <= '0;
      sample_valid_o <= 1'b0;
      err_overrun_o <= 1'b0;
      err_timeout_o <= 1'b0;
`ifdef VOICE_SCHED_MIX_EN
      mix_o <= '0;
`endif
    end else begin
      sample_valid_o <= 1'b0;
      // A new error event in the same cycle as clear_err_i keeps the flag set.
      err_overrun_o <= (sample_tick_i && state != IDLE) || (err_overrun_o && !clear_err_i);
      err_timeout_o <= (state == WAIT && !mv_ready_i && expired) || (err_timeout_o && !clear_err_i);
      case (state)
        IDLE: if (sample_tick_i) begin
          hold_q <= '{default: '0};
          cur_q <= first[VIDX_W] ? first[VIDX_W-1:0] : cur_q;
          state <= first[VIDX_W] ? START : DONE;
        end
        START: begin
          cnt_q <= '0;
          state <= WAIT;
        end
        WAIT: if (adv) begin
          hold_q[cur_q] <= mv_ready_i ? mv_wave_i : '0;
          cur_q <= nxt[VIDX_W] ? nxt[VIDX_W-1:0] : cur_q;
          state <= nxt[VIDX_W] ? START : DONE;
        end else cnt_q <= cnt_q + 1'b1;
        default: begin
          for (int i = 0; i < NUM_VOICES; i++) voice_o[i*SAMPLE_W +: SAMPLE_W] <= hold_q[i];
`ifdef VOICE_SCHED_MIX_EN
          mix_o <= mix_sum;
`endif
          sample_valid_o <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: scoreboard bench for voice_scheduler with a 3-cycle engine model
module tb_voice_scheduler;
  logic clk_i = 1'b0, rst_ni = 1'b0, sample_tick_i = 1'b0, clear_err_i = 1'b0, mv_ready_i = 1'b0;
  logic [2:0] voice_en_i, sync_i, ring_i;
  logic [47:0] freq_i;
  logic [35:0] pw_i;
  logic [11:0] wave_sel_i;
  logic signed [9:0] mv_wave_i = '0;
  logic mv_start_o, mv_sync_o, mv_ring_o, sample_valid_o, busy_o, err_overrun_o, err_timeout_o;
  logic [1:0] mv_voice_o;
  logic [15:0] mv_freq_o;
  logic [11:0] mv_pw_o;
  logic [3:0] mv_wave_o;
  logic [29:0] voice_o;
`ifdef VOICE_SCHED_MIX_EN
  logic signed [11:0] mix_o;
`endif
  voice_scheduler dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sample_tick_i(sample_tick_i), .voice_en_i(voice_en_i),
    .freq_i(freq_i), .pw_i(pw_i), .wave_sel_i(wave_sel_i), .sync_i(sync_i), .ring_i(ring_i),
    .clear_err_i(clear_err_i), .mv_start_o(mv_start_o), .mv_voice_o(mv_voice_o),
    .mv_freq_o(mv_freq_o), .mv_pw_o(mv_pw_o), .mv_wave_o(mv_wave_o), .mv_sync_o(mv_sync_o),
    .mv_ring_o(mv_ring_o), .mv_ready_i(mv_ready_i), .mv_wave_i(mv_wave_i), .voice_o(voice_o),
    .sample_valid_o(sample_valid_o), .busy_o(busy_o), .err_overrun_o(err_overrun_o),
    .err_timeout_o(err_timeout_o)
`ifdef VOICE_SCHED_MIX_EN
    , .mix_o(mix_o)
`endif
  );
  always #10 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;
  typedef struct {logic [29:0] v; int c; logic signed [11:0] m;} exp_t;
  exp_t sb[$];
  exp_t e;
  int st_cyc[$], st_v[$];
  logic [15:0] st_f[$];
  logic signed [9:0] samp [3];
  int tick_cyc = 0, hang_v = -1, eng_cnt = 0, eng_v = 0, pass_n = 0, total_n = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_i);
      sample_tick_i = 1'b0;
      clear_err_i = 1'b0;
    end
  endtask
  task automatic tick(input bit push, input logic [29:0] ev, input int lat, input logic signed [11:0] em);
    step(1);
    sample_tick_i = 1'b1;
    tick_cyc = cyc;
    st_cyc.delete();
    st_v.delete();
    st_f.delete();
    if (push) sb.push_back(exp_t'{ev, cyc + lat, em});
  endtask
  task automatic wait_frame();
    int n = 0;
    while ((sb.size() != 0 || busy_o) && n < 300) begin
      step(1);
      n++;
    end
    if (n >= 300) begin
      total_n++;
      $display("FAIL frame_wait: busy=%0d pending=%0d expected idle with no pending frames", busy_o, sb.size());
    end
    step(2);
  endtask
  // Engine model: ready (with the voice's sample) three cycles after each start, unless the voice hangs.
  initial forever begin
    @(negedge clk_i);
    mv_ready_i = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        mv_ready_i = 1'b1;
        mv_wave_i = samp[eng_v];
      end
    end
    if (mv_start_o) begin
      eng_v = int'(mv_voice_o);
      eng_cnt = (eng_v == hang_v) ? 0 : 3;
      st_cyc.push_back(cyc - tick_cyc);
      st_v.push_back(eng_v);
      st_f.push_back(mv_freq_o);
    end
  end
  // Monitor: every valid pulse must match the oldest expected frame, including its cycle.
  initial forever begin
    @(negedge clk_i);
    if (sample_valid_o) begin
      if (sb.size() == 0) chk("unexpected_valid", 32'(sample_valid_o), 0);
      else begin
        e = sb.pop_front();
        chk("frame_voice", 32'(voice_o), 32'(e.v));
        chk("frame_cycle", cyc, e.c);
`ifdef VOICE_SCHED_MIX_EN
        chk("frame_mix", 32'(mix_o), 32'(e.m));
`endif
      end
    end
  end
  initial begin
    samp[0] = 10'sd100;
    samp[1] = -10'sd200;
    samp[2] = 10'sd300;
    voice_en_i = 3'b111;
    freq_i = {16'h3333, 16'h2222, 16'h1234};
    pw_i = 36'h0;
    wave_sel_i = 12'h421;
    sync_i = 3'b000;
    ring_i = 3'b000;
    step(3);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_voice", 32'(voice_o), 0);
    chk("rst_flags", 32'({mv_start_o, sample_valid_o, err_overrun_o, err_timeout_o}), 0);
    chk("rst_mv", 32'({mv_voice_o, mv_freq_o}), 0);
    rst_ni = 1'b1;
    tick(1, {10'h12C, 10'h338, 10'h064}, 14, 12'sd200);
    wait_frame();
    chk("t1_starts", st_cyc.size() == 3 ? st_cyc[0] * 10000 + st_cyc[1] * 100 + st_cyc[2] : -1, 10509);
    voice_en_i = 3'b000;
    tick(1, 30'h0, 2, 12'sd0);
    wait_frame();
    chk("dis_starts", st_v.size(), 0);
    voice_en_i = 3'b101;
    tick(1, {10'h12C, 10'h000, 10'h064}, 10, 12'sd400);
    wait_frame();
    chk("t2_voices", st_v.size() == 2 ? st_v[0] * 10 + st_v[1] : -1, 2);
    chk("t2_starts", st_cyc.size() == 2 ? st_cyc[0] * 100 + st_cyc[1] : -1, 105);
    voice_en_i = 3'b111;
    tick(1, {10'h12C, 10'h338, 10'h064}, 14, 12'sd200);
    step(3);
    freq_i[15:0] = 16'h4321;
    step(1);
    chk("t3_hold_freq", 32'({mv_voice_o, mv_freq_o}), 32'({2'd0, 16'h1234}));
    wait_frame();
    chk("t3_frame1_freq", 32'(st_f[0]), 32'h1234);
    tick(1, {10'h12C, 10'h338, 10'h064}, 14, 12'sd200);
    wait_frame();
    chk("t3_frame2_freq", 32'(st_f[0]), 32'h4321);
    hang_v = 1;
    tick(1, {10'h12C, 10'h000, 10'h064}, 26, 12'sd400);
    step(20);
    chk("t4_timeout_before", 32'(err_timeout_o), 0);
    step(1);
    chk("t4_timeout_after", 32'(err_timeout_o), 1);
    wait_frame();
    chk("t4_voices", st_v.size() == 3 ? st_v[0] * 100 + st_v[1] * 10 + st_v[2] : -1, 12);
    hang_v = -1;
    clear_err_i = 1'b1;
    step(1);
    chk("t4_clear", 32'(err_timeout_o), 0);
    tick(1, {10'h12C, 10'h338, 10'h064}, 14, 12'sd200);
    step(6);
    sample_tick_i = 1'b1;
    step(1);
    chk("t5_overrun", 32'(err_overrun_o), 1);
    wait_frame();
    chk("t5_starts", st_cyc.size() == 3 ? st_cyc[0] * 10000 + st_cyc[1] * 100 + st_cyc[2] : -1, 10509);
    chk("t5_sticky", 32'(err_overrun_o), 1);
    clear_err_i = 1'b1;
    step(1);
    chk("t5_clear", 32'(err_overrun_o), 0);
    tick(1, {10'h12C, 10'h338, 10'h064}, 14, 12'sd200);
    step(13);
    sample_tick_i = 1'b1;
    step(1);
    chk("t5_done_tick_flag", 32'(err_overrun_o), 1);
    step(1);
    chk("t5_done_tick_idle", 32'(busy_o), 0);
    wait_frame();
    clear_err_i = 1'b1;
    step(1);
    samp[0] = 10'sd511;
    samp[1] = 10'sd511;
    samp[2] = 10'h200;
    tick(1, {10'h200, 10'h1FF, 10'h1FF}, 14, 12'sd510);
    wait_frame();
    tick(0, 30'h0, 0, 12'sd0);
    step(7);
    rst_ni = 1'b0;
    step(1);
    chk("t6_rst_busy", 32'(busy_o), 0);
    chk("t6_rst_flags", 32'({sample_valid_o, mv_start_o, err_overrun_o, err_timeout_o}), 0);
    chk("t6_rst_voice", 32'(voice_o), 0);
`ifdef VOICE_SCHED_MIX_EN
    chk("t6_rst_mix", 32'(mix_o), 0);
`endif
    rst_ni = 1'b1;
    step(30);
    chk("t6_no_frame", 32'({busy_o, sample_valid_o}), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
